// File: rtl/vfx_stream_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : vfx_stream_pkg
//  Description : Shared types and constants for the video-effect stream
//                sequencer (stream FSM encoding, packet type codes, defaults).
//  Revision    : 1.0 - initial release
// ============================================================================
package vfx_stream_pkg;

  // Packet-tracking state of the monitored Avalon-ST stream
  typedef enum logic [1:0] {
    WAIT_SOP = 2'd0,
    IN_VIDEO = 2'd1,
    IN_CTRL  = 2'd2
  } stream_state_t;

  // Low nibble of the sop beat identifying a video (pixel) packet
  localparam logic [3:0] PKT_TYPE_VIDEO = 4'h0;

  localparam int DEFAULT_MODE_W       = 4;
  localparam int DEFAULT_FRAME_PIXELS = 76800;

endpackage : vfx_stream_pkg
`default_nettype wire

// File: rtl/switch_debouncer.sv
`default_nettype none
// ============================================================================
//  Module      : switch_debouncer
//  Description : Two-flop synchroniser followed by a hold-time debouncer for
//                a bank of asynchronous switches. A new value is accepted only
//                after it has been seen unchanged for DEBOUNCE_CYCLES clocks.
//  Revision    : 1.0 - initial release
// ============================================================================
module switch_debouncer #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_sw_async,
  output logic [WIDTH-1:0] o_sw_stable
);

  // Counter only ever needs to reach DEBOUNCE_CYCLES-1
  localparam int               c_DB_W     = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [c_DB_W-1:0] c_CNT_MAX = c_DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [c_DB_W-1:0] c_CNT_ONE = c_DB_W'(1);

  logic [WIDTH-1:0]  r_sw_meta;
  logic [WIDTH-1:0]  r_sw_sync;
  logic [WIDTH-1:0]  r_candidate;
  logic [WIDTH-1:0]  r_stable;
  logic [c_DB_W-1:0] r_cnt;

  // Bring the raw switch levels into the clock domain
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sw_meta <= '0;
      r_sw_sync <= '0;
    end else begin
      r_sw_meta <= i_sw_async;
      r_sw_sync <= r_sw_meta;
    end
  end

  // Restart the hold timer on any change; accept the candidate once it has held
  always_ff @(posedge clk) begin
    if (rst) begin
      r_candidate <= '0;
      r_cnt       <= '0;
      r_stable    <= '0;
    end else if (r_sw_sync != r_candidate) begin
      r_candidate <= r_sw_sync;
      r_cnt       <= '0;
    end else begin
      if (r_cnt != c_CNT_MAX) begin
        r_cnt <= r_cnt + c_CNT_ONE;
      end
      if (r_cnt == c_CNT_MAX) begin
        r_stable <= r_candidate;
      end
    end
  end

  assign o_sw_stable = r_stable;

endmodule : switch_debouncer
`default_nettype wire

// File: rtl/stream_mode_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : stream_mode_sequencer
//  Description : Frame-synchronous effect-mode controller. Debounces the mode
//                switches, tracks packet boundaries on the monitored video
//                stream and commits mode changes only between packets. Also
//                provides frame/pixel counters and a protocol-error strobe.
//  Revision    : 1.0 - initial release
// ============================================================================
module stream_mode_sequencer
  import vfx_stream_pkg::*;
#(
  parameter int MODE_W          = DEFAULT_MODE_W,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int FRAME_PIXELS    = DEFAULT_FRAME_PIXELS,
  parameter int CNT_W           = 17
) (
  input  logic              clk_clk,
  input  logic              reset_reset,
  input  logic [MODE_W-1:0] sw_mode,
  input  logic              sw_freeze,
  input  logic              st_valid,
  input  logic              st_ready,
  input  logic              st_sop,
  input  logic              st_eop,
  input  logic [3:0]        st_type,
  output logic [MODE_W-1:0] mode_active,
  output logic              mode_pending,
  output logic              apply_pulse,
  output logic [15:0]       frame_count,
  output logic [CNT_W-1:0]  pixel_count,
  output logic              sync_error
);

  localparam logic [CNT_W-1:0] c_FRAME_PIXELS = CNT_W'(FRAME_PIXELS);
  localparam logic [CNT_W-1:0] c_PIX_ONE      = CNT_W'(1);

  logic [MODE_W-1:0] w_mode_stable;
  logic              r_freeze_meta;
  logic              r_freeze_sync;
  logic              w_beat;
  logic              w_sop_beat;
  logic              w_eop_beat;
  logic              w_is_video;
  logic              w_commit;

  stream_state_t     r_state;
  logic [MODE_W-1:0] r_mode_active;
  logic              r_mode_pending;
  logic              r_apply_pulse;
  logic [15:0]       r_frame_count;
  logic [CNT_W-1:0]  r_pixel_count;
  logic              r_sync_error;
  logic              r_eop_armed;   // cleared by reset: first eop may belong to a cut-off frame
  logic              r_overflow;    // overrun already reported for this packet

  switch_debouncer #(
    .WIDTH           (MODE_W),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_mode_debouncer (
    .clk         (clk_clk),
    .rst         (reset_reset),
    .i_sw_async  (sw_mode),
    .o_sw_stable (w_mode_stable)
  );

  // Freeze is a level control; synchronising it is enough
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      r_freeze_meta <= 1'b0;
      r_freeze_sync <= 1'b0;
    end else begin
      r_freeze_meta <= sw_freeze;
      r_freeze_sync <= r_freeze_meta;
    end
  end

  assign w_beat     = st_valid & st_ready;
  assign w_sop_beat = w_beat & st_sop;
  assign w_eop_beat = w_beat & st_eop;
  assign w_is_video = (st_type == PKT_TYPE_VIDEO);

  // A mode may change only while no packet is in flight or on its closing beat
  assign w_commit = (w_mode_stable != r_mode_active) && !r_freeze_sync &&
                    (((r_state == WAIT_SOP) && !w_sop_beat) ||
                     ((r_state != WAIT_SOP) && w_eop_beat));

  // Apply committed mode and flag outstanding requests
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      r_mode_active  <= '0;
      r_mode_pending <= 1'b0;
      r_apply_pulse  <= 1'b0;
    end else begin
      r_apply_pulse  <= w_commit;
      r_mode_pending <= (w_mode_stable != r_mode_active);
      if (w_commit) begin
        r_mode_active <= w_mode_stable;
      end
    end
  end

  // Packet boundary tracking, frame/pixel counting and anomaly detection
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      r_state       <= WAIT_SOP;
      r_frame_count <= '0;
      r_pixel_count <= '0;
      r_sync_error  <= 1'b0;
      r_eop_armed   <= 1'b0;
      r_overflow    <= 1'b0;
    end else begin
      r_sync_error <= 1'b0;
      if (w_eop_beat) begin
        r_eop_armed <= 1'b1;
      end
      if (w_sop_beat) begin
        // A new header always restarts tracking; mid-packet it aborts the old one
        if (r_state != WAIT_SOP) begin
          r_sync_error <= 1'b1;
        end
        r_pixel_count <= '0;
        r_overflow    <= 1'b0;
        if (w_eop_beat) begin
          r_state <= WAIT_SOP;
          if (w_is_video) begin
            r_frame_count <= r_frame_count + 16'd1;
          end
        end else begin
          r_state <= w_is_video ? IN_VIDEO : IN_CTRL;
        end
      end else if (w_beat) begin
        case (r_state)
          WAIT_SOP: begin
            if (w_eop_beat && r_eop_armed) begin
              r_sync_error <= 1'b1;
            end
          end
          IN_VIDEO: begin
            if (r_pixel_count == c_FRAME_PIXELS) begin
              if (!r_overflow) begin
                r_sync_error <= 1'b1;
              end
              r_overflow <= 1'b1;
            end else begin
              r_pixel_count <= r_pixel_count + c_PIX_ONE;
            end
            if (w_eop_beat) begin
              r_frame_count <= r_frame_count + 16'd1;
              r_state       <= WAIT_SOP;
            end
          end
          IN_CTRL: begin
            if (w_eop_beat) begin
              r_state <= WAIT_SOP;
            end
          end
          default: r_state <= WAIT_SOP;
        endcase
      end
    end
  end

  assign mode_active  = r_mode_active;
  assign mode_pending = r_mode_pending;
  assign apply_pulse  = r_apply_pulse;
  assign frame_count  = r_frame_count;
  assign pixel_count  = r_pixel_count;
  assign sync_error   = r_sync_error;

endmodule : stream_mode_sequencer
`default_nettype wire

// File: tb/tb_stream_mode_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_stream_mode_sequencer
//  Description : Self-checking bench for stream_mode_sequencer with short
//                debounce and frame sizes.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_stream_mode_sequencer;

  localparam int MODE_W = 4;
  localparam int DB     = 8;
  localparam int FP     = 16;
  localparam int CNT_W  = 5;

  logic              clk = 1'b0;
  logic              rst;
  logic [MODE_W-1:0] sw_mode;
  logic              sw_freeze;
  logic              st_valid, st_ready, st_sop, st_eop;
  logic [3:0]        st_type;
  logic [MODE_W-1:0] mode_active;
  logic              mode_pending, apply_pulse, sync_error;
  logic [15:0]       frame_count;
  logic [CNT_W-1:0]  pixel_count;

  int total = 0;
  int bad   = 0;
  int q_mode[$];

  typedef struct {
    logic       rst, v, r, sop, eop;
    logic [3:0] typ;
    int         err, pix, frm;
  } row_t;
  row_t rows[20];

  stream_mode_sequencer #(
    .MODE_W(MODE_W), .DEBOUNCE_CYCLES(DB), .FRAME_PIXELS(FP), .CNT_W(CNT_W)
  ) dut (
    .clk_clk(clk), .reset_reset(rst), .sw_mode(sw_mode), .sw_freeze(sw_freeze),
    .st_valid(st_valid), .st_ready(st_ready), .st_sop(st_sop), .st_eop(st_eop),
    .st_type(st_type), .mode_active(mode_active), .mode_pending(mode_pending),
    .apply_pulse(apply_pulse), .frame_count(frame_count),
    .pixel_count(pixel_count), .sync_error(sync_error)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic idle();
    st_valid = 1'b0; st_sop = 1'b0; st_eop = 1'b0;
  endtask

  // Commit scoreboard: each apply_pulse must match the oldest expected mode
  always @(posedge clk) begin
    #1;
    if (apply_pulse) begin
      total++;
      if (q_mode.size() == 0) begin
        bad++;
        $display("FAIL commit: unexpected apply_pulse, mode_active=%0d", mode_active);
      end else begin
        int exp;
        exp = q_mode.pop_front();
        if (mode_active != MODE_W'(exp)) begin
          bad++;
          $display("FAIL commit: mode_active=%0d expected %0d", mode_active, exp);
        end
      end
    end
  end

  task automatic wait_commits(input string name, input int bound);
    for (int i = 0; i < bound && q_mode.size() != 0; i++) tick();
    chk(name, q_mode.size(), 0);
  endtask

  // Header beat then n payload beats, eop on the last; reports error strobes
  task automatic send_pkt(input logic [3:0] typ, input int n,
                          output int err_cnt, output int err_beat);
    err_cnt = 0; err_beat = -1;
    st_valid = 1'b1; st_ready = 1'b1; st_sop = 1'b1; st_eop = 1'b0; st_type = typ;
    tick();
    if (sync_error) begin err_cnt++; err_beat = 0; end
    for (int b = 1; b <= n; b++) begin
      st_sop = 1'b0; st_eop = (b == n);
      tick();
      if (sync_error) begin err_cnt++; err_beat = b; end
    end
    idle();
    tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "timeout");
  end

  initial begin
    int ec, eb, pend_seen;

    rst = 1'b1; sw_mode = '0; sw_freeze = 1'b0; st_ready = 1'b0; st_type = 4'h0;
    idle();
    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk("reset mode_active", mode_active, 0);
    chk("reset mode_pending", mode_pending, 0);
    chk("reset apply_pulse", apply_pulse, 0);
    chk("reset frame_count", frame_count, 0);
    chk("reset pixel_count", pixel_count, 0);
    chk("reset sync_error", sync_error, 0);

    // Idle stream: mode request commits immediately once debounced
    sw_mode = 4'd3; q_mode.push_back(3);
    pend_seen = 0;
    for (int i = 0; i < 30 && q_mode.size() != 0; i++) begin
      tick();
      if (mode_pending) pend_seen = 1;
    end
    chk("idle pending rose", pend_seen, 1);
    wait_commits("idle commit", 5);
    chk("idle mode_active", mode_active, 3);
    chk("idle frame_count", frame_count, 0);

    // Request arriving mid-packet waits for the closing beat
    st_valid = 1'b1; st_ready = 1'b1; st_sop = 1'b1; st_eop = 1'b0; st_type = 4'h0;
    tick();
    chk("video sop error", sync_error, 0);
    for (int b = 1; b <= FP; b++) begin
      st_sop = 1'b0; st_eop = (b == FP);
      if (b == 1) begin sw_mode = 4'd5; q_mode.push_back(5); end
      tick();
      if (b == 14) begin
        chk("midpkt pending", mode_pending, 1);
        chk("midpkt mode held", mode_active, 3);
      end
    end
    idle();
    chk("eop mode_active", mode_active, 5);
    chk("eop apply_pulse", apply_pulse, 1);
    chk("eop frame_count", frame_count, 1);
    chk("eop pixel_count", pixel_count, FP);
    tick();
    chk("after eop apply_pulse", apply_pulse, 0);
    chk("commit queue drained", q_mode.size(), 0);

    // Switch glitch shorter than the hold time is rejected
    sw_mode = 4'd2; q_mode.push_back(2);
    wait_commits("set mode 2", 40);
    repeat (3) tick();
    sw_mode = 4'd7; repeat (3) tick();
    sw_mode = 4'd2;
    pend_seen = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (mode_pending) pend_seen = 1;
    end
    chk("glitch pending", pend_seen, 0);
    chk("glitch mode_active", mode_active, 2);

    // Freeze holds the mode across frames; releasing it commits
    sw_freeze = 1'b1; repeat (3) tick();
    sw_mode = 4'd9;
    send_pkt(4'h0, FP, ec, eb);
    send_pkt(4'h0, FP, ec, eb);
    chk("freeze mode_active", mode_active, 2);
    chk("freeze pending", mode_pending, 1);
    chk("freeze frame_count", frame_count, 3);
    sw_freeze = 1'b0; q_mode.push_back(9);
    wait_commits("unfreeze commit", 20);
    tick(); tick();
    chk("unfreeze mode_active", mode_active, 9);
    chk("unfreeze pending", mode_pending, 0);

    // Control packet is not counted; oversize video packet flags one error
    send_pkt(4'hF, 3, ec, eb);
    chk("ctrl errors", ec, 0);
    chk("ctrl frame_count", frame_count, 3);
    chk("ctrl pixel_count", pixel_count, 0);
    send_pkt(4'h0, 20, ec, eb);
    chk("oversize error count", ec, 1);
    chk("oversize error beat", eb, 17);
    chk("oversize frame_count", frame_count, 4);
    chk("oversize pixel_count", pixel_count, FP);

    // Return switches to the reset value so the table sees no commits
    sw_mode = 4'd0; q_mode.push_back(0);
    wait_commits("mode back to 0", 40);

    //        rst   v     r     sop   eop   type   err pix frm
    rows[0]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'h0, 0, 0, 4};
    rows[1]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 0, 1, 4};
    rows[2]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 0, 2, 4};
    rows[3]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 0, 0, 0};
    rows[4]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 0, 0, 0};
    rows[5]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 4'h0, 0, 0, 0};
    rows[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'h0, 0, 0, 0};
    rows[7]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 4'h0, 1, 0, 0};
    rows[8]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 0, 0, 0};
    rows[9]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'h0, 0, 0, 0};
    rows[10] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 0, 1, 0};
    rows[11] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 0, 2, 0};
    rows[12] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 0, 3, 0};
    rows[13] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'h0, 1, 0, 0};
    rows[14] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 0, 1, 0};
    rows[15] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 4'h0, 0, 2, 1};
    rows[16] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 4'h0, 0, 0, 2};
    rows[17] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 4'hF, 0, 0, 2};
    rows[18] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 0, 0, 2};
    rows[19] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 0, 0, 2};

    for (int i = 0; i < 20; i++) begin
      rst = rows[i].rst; st_valid = rows[i].v; st_ready = rows[i].r;
      st_sop = rows[i].sop; st_eop = rows[i].eop; st_type = rows[i].typ;
      tick();
      chk($sformatf("row%0d sync_error", i), sync_error, rows[i].err);
      chk($sformatf("row%0d pixel_count", i), pixel_count, rows[i].pix);
      chk($sformatf("row%0d frame_count", i), frame_count, rows[i].frm);
    end
    rst = 1'b0;
    idle();
    tick();
    chk("final mode_active", mode_active, 0);
    chk("final commit queue", q_mode.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_stream_mode_sequencer
`default_nettype wire
